// File: rtl/accel_pkg.sv
// accel_pkg: shared widths, FSM states and timeout sentinel for the
// dot-product accelerator driver and the accelerator itself.
package accel_pkg;

  localparam int N_ELEM   = 8;
  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;
  localparam int N_WORDS  = 2 * N_ELEM;
  localparam int IDX_W    = $clog2(N_WORDS);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    CAPTURE,
    OUT
  } state_t;

  localparam logic [RESULT_W-1:0] TIMEOUT_SENTINEL =
    64'h8000_0000_0000_0000;

endpackage

// File: rtl/accel_driver_if.sv
// accel_driver_if: operand input stream and result output stream
// between the SoC stream logic (master) and the driver (slave).
interface accel_driver_if;
  import accel_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/accel_watchdog.sv
// accel_watchdog: WAIT-state cycle counter; expired is high during the
// LIMIT-th consecutive enabled cycle after a clear.
module accel_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/accel_driver.sv
// accel_driver: loads 2*N_ELEM operand words, runs one accelerator job,
// returns the 64-bit result. Optional WAIT watchdog: ACCEL_TIMEOUT_EN.
module accel_driver
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  accel_driver_if.slave                 s,
  output logic                          acc_start,
  output logic [N_ELEM-1:0][DATA_W-1:0] acc_a,
  output logic [N_ELEM-1:0][DATA_W-1:0] acc_b,
  input  logic                          acc_done,
  input  logic [RESULT_W-1:0]           acc_result,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int EL_W = $clog2(N_ELEM);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("accel_driver: TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                in_rdy;
  logic                out_vld;
  logic [RESULT_W-1:0] out_q;
  logic                wd_exp;

  assign s.in_ready  = in_rdy;
  assign s.out_valid = out_vld;
  assign s.out_data  = out_q;

`ifdef ACCEL_TIMEOUT_EN
  accel_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == START),
    .en      (state == WAIT),
    .expired (wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD;
      idx         <= '0;
      acc_a       <= '0;
      acc_b       <= '0;
      acc_start   <= 1'b0;
      in_rdy      <= 1'b0;
      out_vld     <= 1'b0;
      out_q       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      unique case (state)
        LOAD: begin
          in_rdy <= 1'b1;
          if (s.in_valid && in_rdy) begin
            // Upper index bit selects the b half of the operand block.
            if (idx[EL_W]) acc_b[idx[EL_W-1:0]] <= s.in_data;
            else           acc_a[idx[EL_W-1:0]] <= s.in_data;
            if (idx == IDX_W'(N_WORDS - 1)) begin
              idx       <= '0;
              state     <= START;
              acc_start <= 1'b1;
              busy      <= 1'b1;
              in_rdy    <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (acc_done) begin
            state <= CAPTURE;
          end else if (wd_exp) begin
            out_q       <= TIMEOUT_SENTINEL;
            out_vld     <= 1'b1;
            timeout_err <= 1'b1;
            state       <= OUT;
          end
        end
        CAPTURE: begin
          out_q   <= acc_result;
          out_vld <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (s.out_ready) begin
            out_vld <= 1'b0;
            busy    <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= LOAD;
          end
        end
        default: begin
          state   <= LOAD;
          busy    <= 1'b0;
          out_vld <= 1'b0;
          in_rdy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_driver.sv
// tb_accel_driver: randomized scoreboard bench with a behavioural
// dot-product accelerator; adds a watchdog job when ACCEL_TIMEOUT_EN.
module tb_accel_driver;
  import accel_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accel_driver_if ifc ();

  logic                          acc_start;
  logic                          acc_done;
  logic                          busy;
  logic                          timeout_err;
  logic [N_ELEM-1:0][DATA_W-1:0] acc_a;
  logic [N_ELEM-1:0][DATA_W-1:0] acc_b;
  logic [RESULT_W-1:0]           acc_result;

  accel_driver #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (ifc),
    .acc_start   (acc_start),
    .acc_a       (acc_a),
    .acc_b       (acc_b),
    .acc_done    (acc_done),
    .acc_result  (acc_result),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  longint exp_q[$];
  int     sb_done = 0;
  int     start_cnt = 0;
  int     out_hs_cyc = 0;
  bit     acc_mute = 1'b0;
  int     bp_req = 0;
  int     done_seq = 0;
  int     done_cyc = 0;

  int t1a[N_ELEM] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int t1b[N_ELEM] = '{10, 10, 10, 10, 1, 1, 1, 1};
  int t2a[N_ELEM] = '{10, -5, 100, -1, 0, 20, -2, 1};
  int t2b[N_ELEM] = '{2, 10, -1, 20, 50, -5, 4, -8};
  int t3a[N_ELEM] = '{15, 25, 35, 45, 55, 65, 75, 85};
  int t3b[N_ELEM] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int ra[N_ELEM];
  int rb[N_ELEM];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string why);
    errors++;
    checks++;
    $display("FAIL %s: bound expired before completion", why);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  endtask

  function automatic longint ref_dot(input int a[N_ELEM],
                                     input int b[N_ELEM]);
    longint sum = 0;
    foreach (a[i]) sum += longint'(a[i]) * longint'(b[i]);
    return sum;
  endfunction

  // Behavioural accelerator: random latency, junk done pulses while idle.
  longint m_res;
  int     m_lat;
  bit     m_pend;
  always @(posedge clk) begin
    #1;
    acc_done = 1'b0;
    if (rst !== 1'b1) begin
      m_pend     = 1'b0;
      acc_result = '0;
    end else if (acc_start) begin
      m_res = 0;
      for (int i = 0; i < N_ELEM; i++)
        m_res += longint'($signed(acc_a[i])) * longint'($signed(acc_b[i]));
      m_lat  = $urandom_range(1, 4);
      m_pend = !acc_mute;
    end else if (m_pend) begin
      if (m_lat == 1) begin
        acc_done   = 1'b1;
        acc_result = m_res;
        m_pend     = 1'b0;
        done_cyc   = cyc;
        done_seq++;
      end else begin
        m_lat--;
      end
    end else if (!busy && $urandom_range(0, 3) == 0) begin
      acc_done   = 1'b1;
      acc_result = {$urandom, $urandom};
    end
  end

  int bp_cnt = 0;
  bit ov_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ifc.out_valid === 1'b1 && !ov_seen) begin
      ov_seen = 1'b1;
      bp_cnt  = bp_req;
    end
    if (ifc.out_valid !== 1'b1) ov_seen = 1'b0;
    if (bp_cnt > 0) begin
      ifc.out_ready = 1'b0;
      bp_cnt--;
    end else begin
      ifc.out_ready = 1'b1;
    end
  end

  bit          cap = 1'b0;
  logic [63:0] held;
  bit          prev_start = 1'b0;
  int          seen_seq = 0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (acc_start) begin
        start_cnt++;
        chk("start_width", 64'(prev_start), 0);
      end
      prev_start = acc_start;
      if (ifc.out_valid) begin
        if (!cap) begin
          cap  = 1'b1;
          held = ifc.out_data;
          if (done_seq != seen_seq) begin
            chk("done_to_valid", 64'(cyc - done_cyc), 2);
            seen_seq = done_seq;
          end
        end else begin
          chk("out_hold", ifc.out_data, held);
        end
        if (ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_underflow: got %h with nothing expected",
                     ifc.out_data);
          end else begin
            chk("result", ifc.out_data, exp_q.pop_front());
          end
          cap = 1'b0;
          sb_done++;
          out_hs_cyc = cyc + 1;
        end
      end
    end else begin
      cap        = 1'b0;
      prev_start = 1'b0;
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap,
                           output int hs_cyc);
    int guard = 0;
    bit hs;
    forever begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = $urandom;
      end else begin
        ifc.in_valid = 1'b1;
        ifc.in_data  = w;
      end
      hs = (ifc.in_valid && ifc.in_ready) === 1'b1;
      @(posedge clk);
      #1;
      if (hs) break;
      guard++;
      if (guard > 1000) abort_run("in_ready_wait");
    end
    hs_cyc = cyc;
  endtask

  task automatic run_job(input int a[N_ELEM], input int b[N_ELEM],
                         input int gap, input int bp, input bit mute,
                         input bit chk_gapless, input bit chk_b2b);
    longint e;
    int     first_c, c, starts0, target, guard;
    e = mute ? longint'(TIMEOUT_SENTINEL) : ref_dot(a, b);
    exp_q.push_back(e);
    bp_req   = bp;
    acc_mute = mute;
    starts0  = start_cnt;
    target   = sb_done + 1;
    first_c  = 0;
    c        = 0;
    for (int w = 0; w < N_WORDS; w++) begin
      send_word(w < N_ELEM ? a[w] : b[w-N_ELEM], gap, c);
      if (w == 0) first_c = c;
    end
    chk("start_after_last", 64'(acc_start), 1);
    chk("busy_after_last", 64'(busy), 1);
    if (chk_gapless) chk("gapless_16", 64'(c - first_c), 15);
    if (chk_b2b) chk("b2b_first", 64'(first_c - out_hs_cyc), 1);
    guard = 0;
    while (sb_done < target) begin
      chk("in_ready_busy", 64'(ifc.in_ready), 0);
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.in_data  = $urandom;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3 * TO + 300) abort_run("job_wait");
    end
    chk("one_start", 64'(start_cnt - starts0), 1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(ifc.in_ready), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_acc_start"}, 64'(acc_start), 0);
    chk({tag, "_out_valid"}, 64'(ifc.out_valid), 0);
    chk({tag, "_out_data"}, ifc.out_data, 0);
    chk({tag, "_acc_a"}, 64'(|acc_a), 0);
    chk({tag, "_acc_b"}, 64'(|acc_b), 0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 0);
  endtask

  initial begin
    #5_000_000;
    abort_run("global_time");
  end

  initial begin
    int s0, c;
    rst          = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_release", 64'(ifc.in_ready), 1);

    run_job(t1a, t1b, 0, 0, 1'b0, 1'b1, 1'b0);
    run_job(t3a, t3b, 0, 0, 1'b0, 1'b1, 1'b1);
    run_job(t2a, t2b, 30, 5, 1'b0, 1'b0, 1'b0);

    s0 = start_cnt;
    for (int w = 0; w < 9; w++)
      send_word(w < N_ELEM ? t1a[w] : t1b[w-N_ELEM], 0, c);
    ifc.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("abort");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_start", 64'(start_cnt - s0), 0);
    run_job(t1a, t1b, 0, 0, 1'b0, 1'b1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      foreach (ra[i]) begin
        ra[i] = int'($urandom);
        rb[i] = int'($urandom);
      end
      run_job(ra, rb, $urandom_range(0, 40), $urandom_range(0, 4),
              1'b0, 1'b0, 1'b0);
    end

`ifdef ACCEL_TIMEOUT_EN
    run_job(t1a, t1b, 0, 2, 1'b1, 1'b0, 1'b0);
    chk("timeout_err_set", 64'(timeout_err), 1);
    run_job(t1a, t1b, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("timeout_err_sticky", 64'(timeout_err), 1);
`else
    chk("timeout_err_off", 64'(timeout_err), 0);
`endif

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
